// File: rtl/u409_bus_master.sv
// u409_bus_master: 68040-style local-bus initiator on CLK40.
// Arbitrates for the bus, issues single/line cycles and collects nTA/nTEA/nTBI terminations.
module u409_bus_master #(
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter int         MAX_RETRY = 3
) (
  input  logic        CLK40,
  input  logic        TS_RESET,
  input  logic        REQ,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_RNW,
  input  logic [1:0]  REQ_SIZE,
  input  logic [31:0] WDATA,
  output logic [1:0]  WBEAT,
  output logic [31:0] RDATA,
  output logic        RDATA_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        nBR,
  input  logic        nBG,
  input  logic        nBB_IN,
  output logic        nBB_OUT,
  output logic        nBB_OE,
  output logic        BUS_OE,
  output logic        nTS,
  output logic [31:0] A_OUT,
  output logic        RnW_OUT,
  output logic [1:0]  SIZ,
  output logic [31:0] D_OUT,
  input  logic [31:0] D_IN,
  input  logic        nTA,
  input  logic        nTEA,
  input  logic        nTBI
);

  typedef enum logic [2:0] {IDLE, ARB, START, DATA, RECOVER, RELEASE} state_t;

  localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

  state_t      r_state;
  logic [31:0] r_addr;
  logic        r_rnw;
  logic [1:0]  r_size;
  logic [1:0]  r_beat;
  logic        r_inhibit;
  logic [7:0]  r_retry;
  logic [7:0]  r_to;
  logic        r_nbr, r_nts, r_nbb_out, r_nbb_oe, r_bus_oe;
  logic        r_busy, r_done, r_err, r_rvalid;
  logic [31:0] r_rdata, r_a_out;
  logic [1:0]  r_siz;
  logic        r_rnw_out;

  logic        w_is_line;
  logic        w_last_beat;
  logic [1:0]  w_line_idx;
  logic [1:0]  w_next_beat;
  logic [1:0]  w_next_idx;
  logic [31:0] w_beat_addr;

  assign w_is_line   = (r_size == 2'b11);
  assign w_last_beat = !w_is_line || (r_beat == 2'd3);
  assign w_line_idx  = r_addr[3:2] + r_beat;
  assign w_next_beat = r_beat + 2'd1;
  assign w_next_idx  = r_addr[3:2] + w_next_beat;
  assign w_beat_addr = w_is_line ? {r_addr[31:4], w_line_idx, 2'b00} : r_addr;

  always_ff @(posedge CLK40 or posedge TS_RESET) begin
    if (TS_RESET) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rnw     <= 1'b1;
      r_size    <= 2'b00;
      r_beat    <= 2'd0;
      r_inhibit <= 1'b0;
      r_retry   <= '0;
      r_to      <= '0;
      r_nbr     <= 1'b1;
      r_nts     <= 1'b1;
      r_nbb_out <= 1'b1;
      r_nbb_oe  <= 1'b0;
      r_bus_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_a_out   <= '0;
      r_siz     <= 2'b00;
      r_rnw_out <= 1'b1;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (REQ) begin
            r_addr    <= REQ_ADDR;
            r_rnw     <= REQ_RNW;
            r_size    <= REQ_SIZE;
            r_beat    <= 2'd0;
            r_inhibit <= 1'b0;
            r_retry   <= '0;
            r_busy    <= 1'b1;
            if (!nBG && nBB_IN) begin
              r_state <= START;
            end else begin
              r_nbr   <= 1'b0;
              r_state <= ARB;
            end
          end
        end
        ARB: begin
          if (!nBG && nBB_IN) begin
            r_nbr   <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_nts     <= 1'b0;
          r_bus_oe  <= 1'b1;
          r_nbb_oe  <= 1'b1;
          r_nbb_out <= 1'b0;
          r_a_out   <= w_beat_addr;
          r_siz     <= r_inhibit ? 2'b00 : r_size;
          r_rnw_out <= r_rnw;
          r_to      <= '0;
          r_state   <= DATA;
        end
        DATA: begin
          // The nTS cycle itself is never a termination sample, but it does count toward the timeout.
          if (!r_nts) begin
            r_nts <= 1'b1;
            r_to  <= r_to + 8'd1;
          end else if (!nTA && nTEA) begin
            r_to <= '0;
            if (r_rnw) begin
              r_rdata  <= D_IN;
              r_rvalid <= 1'b1;
            end
            if (w_last_beat) begin
              r_done    <= 1'b1;
              r_bus_oe  <= 1'b0;
              r_nbb_out <= 1'b1;
              r_state   <= RELEASE;
            end else begin
              r_beat  <= w_next_beat;
              r_a_out <= {r_addr[31:4], w_next_idx, 2'b00};
              if (r_inhibit || (r_beat == 2'd0 && !nTBI)) begin
                r_inhibit <= 1'b1;
                r_state   <= START;
              end
            end
          end else if (nTA && !nTEA) begin
            r_err     <= 1'b1;
            r_bus_oe  <= 1'b0;
            r_nbb_out <= 1'b1;
            r_state   <= RELEASE;
          end else if (!nTA && !nTEA) begin
            if (r_retry == LP_MAX_RETRY) begin
              r_err     <= 1'b1;
              r_bus_oe  <= 1'b0;
              r_nbb_out <= 1'b1;
              r_state   <= RELEASE;
            end else begin
              r_retry <= r_retry + 8'd1;
              r_state <= RECOVER;
            end
          end else if (r_to >= TIMEOUT - 8'd1) begin
            r_err     <= 1'b1;
            r_bus_oe  <= 1'b0;
            r_nbb_out <= 1'b1;
            r_state   <= RELEASE;
          end else begin
            r_to <= r_to + 8'd1;
          end
        end
        RECOVER: r_state <= START;
        RELEASE: begin
          r_nbb_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign WBEAT       = r_beat;
  assign RDATA       = r_rdata;
  assign RDATA_VALID = r_rvalid;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign ERR         = r_err;
  assign nBR         = r_nbr;
  assign nBB_OUT     = r_nbb_out;
  assign nBB_OE      = r_nbb_oe;
  assign BUS_OE      = r_bus_oe;
  assign nTS         = r_nts;
  assign A_OUT       = r_a_out;
  assign RnW_OUT     = r_rnw_out;
  assign SIZ         = r_siz;
  assign D_OUT       = (r_bus_oe && !r_rnw_out) ? WDATA : 32'd0;

endmodule

// File: tb/tb_u409_bus_master.sv
// Self-checking bench for u409_bus_master: table of single transfers plus
// hand-written line, arbitration, retry, timeout and reset sequences.
module tb_u409_bus_master;

  logic        CLK40 = 1'b0;
  logic        TS_RESET;
  logic        REQ;
  logic [31:0] REQ_ADDR;
  logic        REQ_RNW;
  logic [1:0]  REQ_SIZE;
  logic [31:0] WDATA;
  logic [1:0]  WBEAT;
  logic [31:0] RDATA;
  logic        RDATA_VALID, BUSY, DONE, ERR, nBR;
  logic        nBG, nBB_IN, nBB_OUT, nBB_OE, BUS_OE, nTS;
  logic [31:0] A_OUT;
  logic        RnW_OUT;
  logic [1:0]  SIZ;
  logic [31:0] D_OUT, D_IN;
  logic        nTA, nTEA, nTBI;

  u409_bus_master dut (
    .CLK40(CLK40), .TS_RESET(TS_RESET),
    .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_RNW(REQ_RNW), .REQ_SIZE(REQ_SIZE),
    .WDATA(WDATA), .WBEAT(WBEAT), .RDATA(RDATA), .RDATA_VALID(RDATA_VALID),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .nBR(nBR), .nBG(nBG), .nBB_IN(nBB_IN), .nBB_OUT(nBB_OUT), .nBB_OE(nBB_OE),
    .BUS_OE(BUS_OE), .nTS(nTS), .A_OUT(A_OUT), .RnW_OUT(RnW_OUT), .SIZ(SIZ),
    .D_OUT(D_OUT), .D_IN(D_IN), .nTA(nTA), .nTEA(nTEA), .nTBI(nTBI)
  );

  always #10 CLK40 = ~CLK40;

  logic [31:0] wdata_tbl [4];
  always_comb WDATA = wdata_tbl[WBEAT];

  int total = 0;
  int bad   = 0;
  int nts_cnt = 0, rv_cnt = 0, done_cnt = 0, err_cnt = 0;

  // Event counters sample the registered outputs on the active edge.
  always @(posedge CLK40) begin
    if (nTS === 1'b0)         nts_cnt  <= nts_cnt + 1;
    if (RDATA_VALID === 1'b1) rv_cnt   <= rv_cnt + 1;
    if (DONE === 1'b1)        done_cnt <= done_cnt + 1;
    if (ERR === 1'b1)         err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_nbr"}, nBR, 1'b1);
    chk1({tag, "_nts"}, nTS, 1'b1);
    chk1({tag, "_nbb_out"}, nBB_OUT, 1'b1);
    chk1({tag, "_nbb_oe"}, nBB_OE, 1'b0);
    chk1({tag, "_bus_oe"}, BUS_OE, 1'b0);
    chk1({tag, "_busy"}, BUSY, 1'b0);
    chk1({tag, "_done"}, DONE, 1'b0);
    chk1({tag, "_err"}, ERR, 1'b0);
    chk1({tag, "_rvalid"}, RDATA_VALID, 1'b0);
    chk({tag, "_a_out"}, A_OUT, 32'h0);
    chk({tag, "_siz"}, 32'(SIZ), 32'h0);
    chk1({tag, "_rnw_out"}, RnW_OUT, 1'b1);
    chk({tag, "_d_out"}, D_OUT, 32'h0);
    chk({tag, "_rdata"}, RDATA, 32'h0);
    chk({tag, "_wbeat"}, 32'(WBEAT), 32'h0);
  endtask

  task automatic issue(input logic [31:0] addr, input logic rnw, input logic [1:0] size);
    REQ = 1'b1; REQ_ADDR = addr; REQ_RNW = rnw; REQ_SIZE = size;
    tick();
    REQ = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] din;
    logic        tea;
    logic [31:0] exp_a;
    logic [1:0]  exp_siz;
    logic        exp_done;
    logic        exp_err;
    logic        exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 5;
  vec_t vt [NV];

  initial begin
    vec_t v;
    int   k;
    logic got;
    int   nts0, rv0, done0, err0;
    logic [31:0] exp_addr [4];
    logic [31:0] rd_vals [4];

    vt[0] = '{32'h00F80004, 1'b1, 2'd0, 32'h0,        32'h12345678, 1'b0, 32'h00F80004, 2'd0, 1'b1, 1'b0, 1'b1, 32'h12345678};
    vt[1] = '{32'h10000003, 1'b0, 2'd1, 32'h000000A5, 32'h0,        1'b0, 32'h10000003, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{32'h20000002, 1'b1, 2'd2, 32'h0,        32'hCAFEBABE, 1'b1, 32'h20000002, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[3] = '{32'hFFFFFFFC, 1'b0, 2'd0, 32'h5A5A0F0F, 32'h0,        1'b1, 32'hFFFFFFFC, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[4] = '{32'h00000001, 1'b1, 2'd1, 32'h0,        32'hA5A5A5A5, 1'b0, 32'h00000001, 2'd1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5};

    wdata_tbl[0] = 32'h0; wdata_tbl[1] = 32'h0; wdata_tbl[2] = 32'h0; wdata_tbl[3] = 32'h0;
    TS_RESET = 1'b1; REQ = 1'b0; REQ_ADDR = '0; REQ_RNW = 1'b1; REQ_SIZE = 2'd0;
    nBG = 1'b0; nBB_IN = 1'b1; nTA = 1'b1; nTEA = 1'b1; nTBI = 1'b1; D_IN = '0;
    tick(); tick();
    check_reset_vals("rst");
    TS_RESET = 1'b0;
    tick();
    chk1("rst_idle_busy", BUSY, 1'b0);
    $display("reset: checked");

    // Parked-grant single transfers, terminated the cycle after nTS.
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      wdata_tbl[0] = v.wdata;
      issue(v.addr, v.rnw, v.size);
      chk1("v_busy", BUSY, 1'b1);
      chk1("v_nts_pre", nTS, 1'b1);
      tick();
      chk1("v_nts_low", nTS, 1'b0);
      chk("v_a_out", A_OUT, v.exp_a);
      chk("v_siz", 32'(SIZ), 32'(v.exp_siz));
      chk1("v_rnw_out", RnW_OUT, v.rnw);
      chk1("v_bus_oe", BUS_OE, 1'b1);
      chk("v_nbb", 32'({nBB_OE, nBB_OUT}), 32'h2);
      chk("v_d_out", D_OUT, v.rnw ? 32'h0 : v.wdata);
      tick();
      chk1("v_nts_high", nTS, 1'b1);
      chk1("v_done_early", DONE, 1'b0);
      nTA = v.tea; nTEA = !v.tea; D_IN = v.din;
      tick();
      nTA = 1'b1; nTEA = 1'b1; D_IN = 32'hDEADBEEF;
      chk1("v_done", DONE, v.exp_done);
      chk1("v_err", ERR, v.exp_err);
      chk1("v_rvalid", RDATA_VALID, v.exp_rv);
      if (v.exp_rv) chk("v_rdata", RDATA, v.exp_rdata);
      chk1("v_bus_oe_rel", BUS_OE, 1'b0);
      tick();
      chk1("v_busy_end", BUSY, 1'b0);
      chk1("v_nbb_oe_end", nBB_OE, 1'b0);
      chk1("v_done_once", DONE, 1'b0);
      $display("vec %0d: addr=%h rnw=%0d size=%0d tea=%0d done=%0d err=%0d", i, v.addr, v.rnw, v.size, v.tea, v.exp_done, v.exp_err);
    end

    // Line write at 0x08 with the grant withheld for three cycles.
    wdata_tbl[0] = 32'h11110000; wdata_tbl[1] = 32'h22221111;
    wdata_tbl[2] = 32'h33332222; wdata_tbl[3] = 32'h44443333;
    exp_addr[0] = 32'h08; exp_addr[1] = 32'h0C; exp_addr[2] = 32'h00; exp_addr[3] = 32'h04;
    nBG = 1'b1;
    nts0 = nts_cnt;
    issue(32'h00000008, 1'b0, 2'd3);
    for (int c = 0; c < 3; c++) begin
      chk1("lw_nbr_wait", nBR, 1'b0);
      chk1("lw_nts_wait", nTS, 1'b1);
      tick();
    end
    chk1("lw_nbr_wait", nBR, 1'b0);
    nBG = 1'b0;
    tick();
    chk1("lw_nbr_rel", nBR, 1'b1);
    tick();
    chk1("lw_nts_low", nTS, 1'b0);
    chk("lw_siz", 32'(SIZ), 32'h3);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk1("lw_nts_beat", nTS, 1'b1);
      chk("lw_a_out", A_OUT, exp_addr[b]);
      chk("lw_wbeat", 32'(WBEAT), 32'(b));
      chk("lw_d_out", D_OUT, wdata_tbl[b]);
      nTA = 1'b0;
      tick();
      chk1("lw_done", DONE, (b == 3));
    end
    nTA = 1'b1;
    tick();
    chk("lw_nts_pulses", 32'(nts_cnt - nts0), 32'd1);
    chk1("lw_busy_end", BUSY, 1'b0);
    $display("line write: 4 beats addr=00000008");

    // Line read with burst inhibit on beat 0; later nTBI is ignored.
    rd_vals[0] = 32'hA0000000; rd_vals[1] = 32'hA1111111;
    rd_vals[2] = 32'hA2222222; rd_vals[3] = 32'hA3333333;
    exp_addr[0] = 32'h1004; exp_addr[1] = 32'h1008; exp_addr[2] = 32'h100C; exp_addr[3] = 32'h1000;
    nts0 = nts_cnt; rv0 = rv_cnt;
    issue(32'h00001004, 1'b1, 2'd3);
    tick();
    chk1("lr_nts0", nTS, 1'b0);
    chk("lr_a0", A_OUT, exp_addr[0]);
    chk("lr_siz0", 32'(SIZ), 32'h3);
    tick();
    nTA = 1'b0; nTBI = 1'b0; D_IN = rd_vals[0];
    tick();
    nTA = 1'b1; nTBI = 1'b1;
    chk1("lr_rv0", RDATA_VALID, 1'b1);
    chk("lr_rd0", RDATA, rd_vals[0]);
    for (int b = 1; b < 4; b++) begin
      tick();
      chk1("lr_nts", nTS, 1'b0);
      chk("lr_a", A_OUT, exp_addr[b]);
      chk("lr_siz", 32'(SIZ), 32'h0);
      tick();
      nTA = 1'b0; nTBI = 1'b0; D_IN = rd_vals[b];
      tick();
      nTA = 1'b1; nTBI = 1'b1;
      chk1("lr_rv", RDATA_VALID, 1'b1);
      chk("lr_rd", RDATA, rd_vals[b]);
      chk1("lr_done", DONE, (b == 3));
    end
    tick();
    chk("lr_nts_pulses", 32'(nts_cnt - nts0), 32'd4);
    chk("lr_rv_pulses", 32'(rv_cnt - rv0), 32'd4);
    $display("line read inhibited: 4 cycles addr=00001004");

    // nTA+nTEA four times: three retries then ERR.
    nts0 = nts_cnt; done0 = done_cnt;
    issue(32'h00000040, 1'b1, 2'd0);
    tick();
    tick();
    for (int r = 0; r < 4; r++) begin
      nTA = 1'b0; nTEA = 1'b0;
      tick();
      nTA = 1'b1; nTEA = 1'b1;
      if (r < 3) begin
        chk1("rt_err_early", ERR, 1'b0);
        chk1("rt_recover_nts", nTS, 1'b1);
        tick();
        tick();
        chk1("rt_nts_again", nTS, 1'b0);
        tick();
      end else begin
        chk1("rt_err", ERR, 1'b1);
        chk1("rt_bus_oe", BUS_OE, 1'b0);
        chk1("rt_nbb_out", nBB_OUT, 1'b1);
      end
    end
    tick();
    chk1("rt_nbb_oe", nBB_OE, 1'b0);
    chk1("rt_busy", BUSY, 1'b0);
    chk("rt_nts_pulses", 32'(nts_cnt - nts0), 32'd4);
    chk("rt_no_done", 32'(done_cnt - done0), 32'd0);
    $display("retry: 3 retries then error");

    // No termination at all: ERR after TIMEOUT cycles from nTS falling.
    issue(32'h00000080, 1'b0, 2'd0);
    tick();
    chk1("to_nts_low", nTS, 1'b0);
    k = 0; got = 1'b0;
    while (k < 300 && !got) begin
      tick();
      k++;
      if (ERR === 1'b1) got = 1'b1;
    end
    chk1("to_seen", got, 1'b1);
    chk("to_cycles", 32'(k), 32'd255);
    chk1("to_done", DONE, 1'b0);
    chk1("to_nbb_out", nBB_OUT, 1'b1);
    tick();
    chk1("to_nbb_oe", nBB_OE, 1'b0);
    $display("timeout: error after %0d cycles", k);

    // Reset during the data phase of a line read.
    done0 = done_cnt; err0 = err_cnt;
    issue(32'h00000200, 1'b1, 2'd3);
    tick();
    tick();
    nTA = 1'b0; D_IN = 32'h5555AAAA;
    tick();
    nTA = 1'b1;
    chk1("mr_rv0", RDATA_VALID, 1'b1);
    #2;
    TS_RESET = 1'b1;
    #1;
    check_reset_vals("mr");
    tick();
    tick();
    TS_RESET = 1'b0;
    tick();
    chk("mr_no_done", 32'(done_cnt - done0), 32'd0);
    chk("mr_no_err", 32'(err_cnt - err0), 32'd0);
    issue(32'h00000300, 1'b1, 2'd0);
    tick();
    chk1("mr_nts_low", nTS, 1'b0);
    chk("mr_a_out", A_OUT, 32'h00000300);
    tick();
    nTA = 1'b0; D_IN = 32'h0BADF00D;
    tick();
    nTA = 1'b1;
    chk1("mr_done", DONE, 1'b1);
    chk("mr_rdata", RDATA, 32'h0BADF00D);
    tick();
    $display("reset mid-transfer: recovered, next read at 00000300");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
